// File: rtl/cu_cbfp_ctrl.sv
// rtl/cu_cbfp_ctrl.sv - CBFP stage control: enable phasing, block/frame tracking, partial-block flag
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   alert_cbfp   one input sample present this cycle
//   flush        synchronous soft-clear of partial-block state
//   mag_en       magnitude detect enable (alert delayed MAG_LAT)
//   exp_latch    last mag_en sample of a block
//   min_en       min-exponent select enable (mag_en delayed MIN_LAT)
//   valid_out    shifted sample valid (min_en delayed OUT_LAT)
//   out_first    valid_out carries sample 0 of a block
//   out_last     valid_out carries sample BLK_LEN-1 of a block
//   blk_idx      output-side block index
//   frame_done   out_last of block NUM_BLK-1
//   busy         any stage or partial block in flight
//   err_partial  one-cycle pulse after a flush that cut a block short

module cu_cbfp_ctrl #(
    parameter int MAG_LAT = 1,
    parameter int MIN_LAT = 1,
    parameter int OUT_LAT = 2,
    parameter int BLK_LEN = 16,
    parameter int NUM_BLK = 32,
    localparam int BW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alert_cbfp,
    input  logic          flush,
    output logic          mag_en,
    output logic          exp_latch,
    output logic          min_en,
    output logic          valid_out,
    output logic          out_first,
    output logic          out_last,
    output logic [BW-1:0] blk_idx,
    output logic          frame_done,
    output logic          busy,
    output logic          err_partial
);

    localparam int L  = MAG_LAT + MIN_LAT + OUT_LAT;
    localparam int CW = $clog2(BLK_LEN);
    localparam logic [CW-1:0] SAMP_LAST = CW'(BLK_LEN - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(NUM_BLK - 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    // The three enable phases are taps on one shift line, so each phase is
    // exactly the previous one delayed by its latency.
    logic [L-1:0]  dl;
    logic [CW-1:0] samp_cnt;
    logic [CW-1:0] out_cnt;
    logic [BW-1:0] blk_q;
    logic          err_q;
    state_t        state_q;
    state_t        state_d;
    logic          samp_last;
    logic          out_wrap;

    assign mag_en      = dl[MAG_LAT-1];
    assign min_en      = dl[MAG_LAT+MIN_LAT-1];
    assign valid_out   = dl[L-1];
    assign samp_last   = (samp_cnt == SAMP_LAST);
    assign out_wrap    = (out_cnt == SAMP_LAST);
    assign exp_latch   = mag_en & samp_last;
    assign out_first   = valid_out & (out_cnt == '0);
    assign out_last    = valid_out & out_wrap;
    assign blk_idx     = blk_q;
    assign frame_done  = out_last & (blk_q == BLK_LAST);
    assign busy        = (state_q != IDLE) | (|dl) | (out_cnt != '0);
    assign err_partial = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mag_en) state_d = FILL;
            FILL: begin
                if (mag_en && samp_last) state_d = IDLE;
                else if (!mag_en)        state_d = HOLD;
            end
            HOLD: begin
                // A block may resume on its very last sample.
                if (mag_en) state_d = samp_last ? IDLE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl       <= '0;
            samp_cnt <= '0;
            out_cnt  <= '0;
            blk_q    <= '0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
        end else if (flush) begin
            // The alert arriving in the flush cycle is deliberately not shifted in.
            dl       <= '0;
            samp_cnt <= '0;
            out_cnt  <= '0;
            blk_q    <= '0;
            err_q    <= (samp_cnt != '0) | (out_cnt != '0);
            state_q  <= IDLE;
        end else begin
            dl      <= {dl[L-2:0], alert_cbfp};
            err_q   <= 1'b0;
            state_q <= state_d;
            if (mag_en) samp_cnt <= samp_last ? '0 : samp_cnt + 1'b1;
            if (valid_out) out_cnt <= out_wrap ? '0 : out_cnt + 1'b1;
            if (out_last) blk_q <= (blk_q == BLK_LAST) ? '0 : blk_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_cu_cbfp_ctrl.sv
// tb/tb_cu_cbfp_ctrl.sv - randomized self-checking bench for cu_cbfp_ctrl (two parameter sets)

module tb_cu_cbfp_ctrl;

    localparam int NH = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic alert_cbfp = 1'b0;
    logic flush = 1'b0;

    // Instance 0: default parameters.
    logic       a_mag, a_el, a_min, a_v, a_of, a_ol, a_fd, a_busy, a_err;
    logic [4:0] a_blk;
    // Instance 1: MAG_LAT=3 MIN_LAT=2 OUT_LAT=4 BLK_LEN=8 NUM_BLK=2.
    logic       b_mag, b_el, b_min, b_v, b_of, b_ol, b_fd, b_busy, b_err;
    logic [0:0] b_blk;

    cu_cbfp_ctrl dut0 (
        .clk(clk), .rst(rst), .alert_cbfp(alert_cbfp), .flush(flush),
        .mag_en(a_mag), .exp_latch(a_el), .min_en(a_min), .valid_out(a_v),
        .out_first(a_of), .out_last(a_ol), .blk_idx(a_blk), .frame_done(a_fd),
        .busy(a_busy), .err_partial(a_err)
    );

    cu_cbfp_ctrl #(.MAG_LAT(3), .MIN_LAT(2), .OUT_LAT(4), .BLK_LEN(8), .NUM_BLK(2)) dut1 (
        .clk(clk), .rst(rst), .alert_cbfp(alert_cbfp), .flush(flush),
        .mag_en(b_mag), .exp_latch(b_el), .min_en(b_min), .valid_out(b_v),
        .out_first(b_of), .out_last(b_ol), .blk_idx(b_blk), .frame_done(b_fd),
        .busy(b_busy), .err_partial(b_err)
    );

    int ml[2] = '{1, 3};
    int nl[2] = '{1, 2};
    int ol[2] = '{2, 4};
    int bl[2] = '{16, 8};
    int nb[2] = '{32, 2};

    // Input history: eff_h = sample actually accepted, clr_h = flush or rst that cycle.
    bit eff_h [NH];
    bit clr_h [NH];
    int cyc = 0;

    int samp[2], outc[2], blk[2];
    bit err_nx[2];

    int n_chk = 0, n_pass = 0;

    int base;
    int f_mag[2], f_min[2], f_v[2], f_el[2], f_of[2], f_ol[2], f_err[2], f_b1[2], f_busy[2];
    int n_v[2], n_el[2], n_of[2], n_ol[2], n_fd[2], n_err[2];

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got %0d want %0d", nm, got, want);
    endtask

    // A sample accepted in cycle s is still in the delay line at cycle t if
    // it is at most L cycles old and no clear happened after it.
    function automatic bit alive(int s, int t);
        if (s < 0) return 1'b0;
        if (!eff_h[s]) return 1'b0;
        for (int c = s + 1; c < t; c++)
            if (clr_h[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pin_clear();
        base = cyc;
        for (int i = 0; i < 2; i++) begin
            f_mag[i] = -1; f_min[i] = -1; f_v[i] = -1; f_el[i] = -1; f_of[i] = -1;
            f_ol[i] = -1; f_err[i] = -1; f_b1[i] = -1; f_busy[i] = -1;
            n_v[i] = 0; n_el[i] = 0; n_of[i] = 0; n_ol[i] = 0; n_fd[i] = 0; n_err[i] = 0;
        end
    endtask

    task automatic first(inout int f, input bit ev);
        if (ev && f < 0) f = cyc - base;
    endtask

    // One cycle: check outputs against the model, then apply this cycle's inputs.
    task automatic step(input bit a, input bit f, input bit r);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int  lt;
            bit  e_mag, e_min, e_v, e_busy, e_el, e_of, e_ol, e_fd;
            logic [8:0] ev, av;
            int  ablk;
            lt    = ml[i] + nl[i] + ol[i];
            e_mag = alive(cyc - ml[i], cyc);
            e_min = alive(cyc - ml[i] - nl[i], cyc);
            e_v   = alive(cyc - lt, cyc);
            e_busy = (samp[i] != 0) || (outc[i] != 0);
            for (int s = cyc - lt; s < cyc; s++)
                if (alive(s, cyc)) e_busy = 1'b1;
            e_el = e_mag && (samp[i] == bl[i] - 1);
            e_of = e_v && (outc[i] == 0);
            e_ol = e_v && (outc[i] == bl[i] - 1);
            e_fd = e_ol && (blk[i] == nb[i] - 1);
            ev = {e_mag, e_el, e_min, e_v, e_of, e_ol, e_fd, e_busy, err_nx[i]};
            if (i == 0) begin
                av   = {a_mag, a_el, a_min, a_v, a_of, a_ol, a_fd, a_busy, a_err};
                ablk = int'(a_blk);
            end else begin
                av   = {b_mag, b_el, b_min, b_v, b_of, b_ol, b_fd, b_busy, b_err};
                ablk = int'(b_blk);
            end
            n_chk++;
            if (av === ev) n_pass++;
            else $display("FAIL outs cyc%0d dut%0d {mag,el,min,v,of,ol,fd,busy,err} got %b want %b",
                          cyc, i, av, ev);
            n_chk++;
            if (ablk == blk[i]) n_pass++;
            else $display("FAIL blk_idx cyc%0d dut%0d got %0d want %0d", cyc, i, ablk, blk[i]);

            first(f_mag[i], e_mag); first(f_min[i], e_min); first(f_v[i], e_v);
            first(f_el[i], e_el);   first(f_of[i], e_of);   first(f_ol[i], e_ol);
            first(f_err[i], err_nx[i]); first(f_b1[i], blk[i] != 0); first(f_busy[i], e_busy);
            n_v[i] += int'(e_v); n_el[i] += int'(e_el); n_of[i] += int'(e_of);
            n_ol[i] += int'(e_ol); n_fd[i] += int'(e_fd); n_err[i] += int'(err_nx[i]);

            err_nx[i] = f && !r && (samp[i] != 0 || outc[i] != 0);
            if (r || f) begin
                samp[i] = 0; outc[i] = 0; blk[i] = 0;
            end else begin
                if (e_mag) samp[i] = (samp[i] + 1) % bl[i];
                if (e_v)   outc[i] = (outc[i] + 1) % bl[i];
                if (e_ol)  blk[i]  = (blk[i] + 1) % nb[i];
            end
        end
        rst        = r;
        flush      = f;
        alert_cbfp = a;
        eff_h[cyc] = a && !f && !r;
        clr_h[cyc] = f || r;
        cyc++;
        if (cyc >= NH) begin
            $display("FAIL history overflow at cyc %0d", cyc);
            $fatal(1);
        end
    endtask

    task automatic do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            samp[i] = 0; outc[i] = 0; blk[i] = 0; err_nx[i] = 1'b0;
        end
        pin_clear();

        // Single alert pulse.
        do_reset();
        pin_clear();
        step(1'b1, 1'b0, 1'b0);
        repeat (14) step(1'b0, 1'b0, 1'b0);
        chk("t1_mag_at",  f_mag[0], 1);
        chk("t1_min_at",  f_min[0], 2);
        chk("t1_v_at",    f_v[0],   4);
        chk("t1_v_once",  n_v[0],   1);
        chk("t1_busy_at", f_busy[0], 1);
        chk("t6_mag_at",  f_mag[1], 3);
        chk("t6_min_at",  f_min[1], 5);
        chk("t6_v_at",    f_v[1],   9);

        // Sixteen back-to-back samples.
        do_reset();
        pin_clear();
        repeat (16) step(1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        chk("t2_el_at",    f_el[0], 16);
        chk("t2_el_once",  n_el[0], 1);
        chk("t2_of_at",    f_of[0], 4);
        chk("t2_ol_at",    f_ol[0], 19);
        chk("t2_blk1_at",  f_b1[0], 20);

        // Block with a three-cycle gap after sample 7.
        do_reset();
        pin_clear();
        repeat (8) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("t3_el_at",   f_el[0], 19);
        chk("t3_el_once", n_el[0], 1);
        chk("t3_ol_at",   f_ol[0], 22);

        // Flush after five samples, then a clean block.
        do_reset();
        pin_clear();
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (16) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("t5_err_at",   f_err[0], 6);
        chk("t5_err_once", n_err[0], 1);
        chk("t5_err_b",    n_err[1], 1);
        chk("t5_of_cnt",   n_of[0], 2);
        chk("t5_ol_cnt",   n_ol[0], 1);
        chk("t5_ol_cnt_b", n_ol[1], 2);

        // Reset mid-block never raises err_partial.
        pin_clear();
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        chk("t6_rst_err_a", n_err[0], 0);
        chk("t6_rst_err_b", n_err[1], 0);

        // Full frame for both instances.
        do_reset();
        pin_clear();
        repeat (512) step(1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("t4_fd_a",   n_fd[0], 1);
        chk("t4_fd_b",   n_fd[1], 32);
        chk("t4_blk0_a", blk[0], 0);
        chk("t4_blk0_b", blk[1], 0);

        // Randomized traffic with occasional flush and reset.
        repeat (2500) begin
            bit a, f, r;
            a = ($urandom_range(0, 99) < 60);
            f = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 999) < 3);
            step(a, f, r);
        end
        repeat (20) step(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
